// File: rtl/wishbone_arbiter_if.sv
// Bus-arbitration handshake bundle for wishbone_arbiter.
// Signals:
//   req_i    per-master CYC request
//   lock_i   per-master bus lock
//   stb_i    STB of the granted master, already muxed
//   term_i   slave ACK|ERR|RTY of the current transfer
//   gnt_o    one-hot grant or all-zero
//   sel_o    binary index of the granted master
//   busy_o   high while a grant is active
//   to_err_o one-cycle timeout abort pulse
// Modports:
//   slave  - arbiter side: takes requests, drives grants
//   master - requester/testbench side: drives requests, observes grants
interface wishbone_arbiter_if #(
  parameter int unsigned N_MASTER = 4
);
  localparam int unsigned SW = $clog2(N_MASTER);

  logic [N_MASTER-1:0] req_i;
  logic [N_MASTER-1:0] lock_i;
  logic                stb_i;
  logic                term_i;
  logic [N_MASTER-1:0] gnt_o;
  logic [SW-1:0]       sel_o;
  logic                busy_o;
  logic                to_err_o;

  modport slave (
    input  req_i, lock_i, stb_i, term_i,
    output gnt_o, sel_o, busy_o, to_err_o
  );

  modport master (
    output req_i, lock_i, stb_i, term_i,
    input  gnt_o, sel_o, busy_o, to_err_o
  );
endinterface

// File: rtl/wishbone_arbiter.sv
// Round-robin Wishbone bus arbiter with bus-lock support and an optional
// stalled-strobe watchdog.
// Ports:
//   clk_i  sole clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    wishbone_arbiter_if.slave (req_i, lock_i, stb_i, term_i in;
//          gnt_o, sel_o, busy_o, to_err_o out, all outputs registered)
// Parameters:
//   N_MASTER        number of requesting masters (2..16)
//   TIMEOUT_CYCLES  stalled-strobe cycles before abort (1..65535)
// Configuration macro:
//   WB_ARB_TIMEOUT_EN  when defined, builds the watchdog counter and the
//                      ABORT path; otherwise to_err_o is tied low.
module wishbone_arbiter #(
  parameter int unsigned N_MASTER       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  wishbone_arbiter_if.slave     bus
);
  localparam int unsigned SW = $clog2(N_MASTER);
  localparam logic [N_MASTER-1:0] ONE_HOT0 = {{(N_MASTER-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t              state_q;
  logic [N_MASTER-1:0] gnt_q;
  logic [SW-1:0]       sel_q;
  logic [SW-1:0]       last_q;
  logic                busy_q;

  // Rotating priority search starting just after the last winner, so the
  // previous owner is always considered last.
  logic          found;
  logic [SW-1:0] win;
  logic [SW-1:0] cand;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_MASTER; k++) begin
      cand = SW'((32'(last_q) + k) % N_MASTER);
      if (!found && bus.req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Owner keeps the bus while it still requests or holds its lock.
  logic hold;
  assign hold = bus.req_i[sel_q] | bus.lock_i[sel_q];

  logic timeout;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] cnt_q;
  logic          to_err_q;

  assign timeout = (cnt_q == TW'(TIMEOUT_CYCLES)) && bus.stb_i && !bus.term_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != BUSY || !bus.stb_i || bus.term_i) begin
      cnt_q <= '0;
    end else if (cnt_q != TW'(TIMEOUT_CYCLES)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.to_err_o = to_err_q;
`else
  logic unused_stall;
  assign unused_stall = bus.stb_i & bus.term_i;
  assign timeout      = 1'b0;
  assign bus.to_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      last_q   <= SW'(N_MASTER - 1);
`ifdef WB_ARB_TIMEOUT_EN
      to_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q <= BUSY;
            gnt_q   <= ONE_HOT0 << win;
            sel_q   <= win;
            last_q  <= win;
            busy_q  <= 1'b1;
          end
        end
        BUSY: begin
          // Watchdog abort overrides the owner's lock.
          if (timeout) begin
            state_q  <= ABORT;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
            to_err_q <= 1'b1;
`endif
          end else if (!hold) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        ABORT: begin
          state_q  <= IDLE;
`ifdef WB_ARB_TIMEOUT_EN
          to_err_q <= 1'b0;
`endif
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_o  = gnt_q;
  assign bus.sel_o  = sel_q;
  assign bus.busy_o = busy_q;
endmodule

// File: tb/tb_wishbone_arbiter.sv
// Self-checking bench for wishbone_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_wishbone_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wishbone_arbiter_if #(.N_MASTER(N)) bus ();

  wishbone_arbiter #(
    .N_MASTER(N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: owner index (-1 when nobody holds the bus), last winner,
  // reported select, abort pulse and stall count.
  int m_owner, m_last, m_sel, m_cnt;
  bit m_err, m_abort;

  function automatic int pick(logic [N-1:0] r, int from_last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (from_last + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge(bit r, logic [N-1:0] rq, logic [N-1:0] lk, bit s, bit t);
    int w;
    if (r) begin
      m_owner = -1; m_last = N - 1; m_sel = 0; m_err = 0; m_cnt = 0; m_abort = 0;
    end else begin
      m_err = 0;
      if (m_abort) begin
        m_abort = 0;
        m_cnt   = 0;
      end else if (m_owner < 0) begin
        w = pick(rq, m_last);
        if (w >= 0) begin
          m_owner = w; m_last = w; m_sel = w;
        end
        m_cnt = 0;
      end else begin
        if (TO_EN && m_cnt == TO && s && !t) begin
          m_abort = 1; m_err = 1; m_owner = -1;
        end else if (!rq[m_owner] && !lk[m_owner]) begin
          m_owner = -1;
        end
        if (!s || t) m_cnt = 0;
        else if (m_cnt < TO) m_cnt++;
      end
    end
  endtask

  task automatic check(string tag);
    logic [N-1:0] eg;
    logic [1:0]   es;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    es = 2'(m_sel);
    tests++;
    assert (bus.gnt_o === eg) else begin
      fails++; $error("FAIL %s gnt observed=%b expected=%b", tag, bus.gnt_o, eg);
    end
    tests++;
    assert (bus.sel_o === es) else begin
      fails++; $error("FAIL %s sel observed=%0d expected=%0d", tag, bus.sel_o, es);
    end
    tests++;
    assert (bus.busy_o === (m_owner >= 0)) else begin
      fails++; $error("FAIL %s busy observed=%b expected=%b", tag, bus.busy_o, m_owner >= 0);
    end
    tests++;
    assert (bus.to_err_o === m_err) else begin
      fails++; $error("FAIL %s to_err observed=%b expected=%b", tag, bus.to_err_o, m_err);
    end
    tests++;
    assert ($onehot0(bus.gnt_o) === 1'b1) else begin
      fails++; $error("FAIL %s onehot observed=%b expected=onehot0", tag, bus.gnt_o);
    end
  endtask

  task automatic expect_gnt(string tag, logic [N-1:0] val);
    tests++;
    assert (bus.gnt_o === val) else begin
      fails++; $error("FAIL %s gnt observed=%b expected=%b", tag, bus.gnt_o, val);
    end
  endtask

  task automatic step(string tag, bit r, logic [N-1:0] rq, logic [N-1:0] lk, bit s, bit t);
    @(negedge clk);
    rst = r; bus.req_i = rq; bus.lock_i = lk; bus.stb_i = s; bus.term_i = t;
    @(posedge clk);
    model_edge(r, rq, lk, s, t);
    #1;
    check(tag);
  endtask

  initial begin
    int waited;
    logic [N-1:0] rq, lk;
    rst = 1'b1; bus.req_i = '0; bus.lock_i = '0; bus.stb_i = 1'b0; bus.term_i = 1'b0;
    m_owner = -1; m_last = N - 1; m_sel = 0; m_cnt = 0; m_err = 0; m_abort = 0;

    // Reset state, then idle with no requests.
    step("reset", 1, '0, '0, 0, 0);
    expect_gnt("reset_gnt", 4'b0000);
    step("idle", 0, '0, '0, 0, 0);
    step("idle2", 0, '0, '0, 0, 0);

    // Round robin with all requesting; owner drops req for one cycle each time.
    step("rr_g0", 0, 4'b1111, '0, 0, 0);  expect_gnt("rr_g0c", 4'b0001);
    step("rr_b0", 0, 4'b1110, '0, 0, 0);  expect_gnt("rr_b0c", 4'b0000);
    step("rr_g1", 0, 4'b1111, '0, 0, 0);  expect_gnt("rr_g1c", 4'b0010);
    step("rr_b1", 0, 4'b1101, '0, 0, 0);  expect_gnt("rr_b1c", 4'b0000);
    step("rr_g2", 0, 4'b1111, '0, 0, 0);  expect_gnt("rr_g2c", 4'b0100);
    step("rr_b2", 0, 4'b1011, '0, 0, 0);  expect_gnt("rr_b2c", 4'b0000);
    step("rr_g3", 0, 4'b1111, '0, 0, 0);  expect_gnt("rr_g3c", 4'b1000);
    step("rr_b3", 0, 4'b0111, '0, 0, 0);  expect_gnt("rr_b3c", 4'b0000);
    step("rr_g0b", 0, 4'b1111, '0, 0, 0); expect_gnt("rr_g0bc", 4'b0001);

    // Lock holds master 2 while its request is down and master 0 waits.
    step("lk_rst", 1, '0, '0, 0, 0);
    step("lk_g2", 0, 4'b0100, 4'b0100, 0, 0); expect_gnt("lk_g2c", 4'b0100);
    for (int i = 0; i < 3; i++) begin
      step("lk_hold", 0, 4'b0001, 4'b0100, 0, 0);
      expect_gnt("lk_holdc", 4'b0100);
    end
    step("lk_rel", 0, 4'b0001, 4'b0000, 0, 0); expect_gnt("lk_relc", 4'b0000);
    step("lk_g0", 0, 4'b0001, 4'b0000, 0, 0);  expect_gnt("lk_g0c", 4'b0001);

    // Simultaneous requests from 0 and 3 with last winner 0.
    step("sim_rel", 0, 4'b0000, '0, 0, 0);
    step("sim_g3", 0, 4'b1001, '0, 0, 0); expect_gnt("sim_g3c", 4'b1000);

    // Reset mid-BUSY drops the grant; master 0 side has top priority after.
    step("mr_rst0", 1, '0, '0, 0, 0);
    step("mr_g3", 0, 4'b1000, '0, 0, 0);   expect_gnt("mr_g3c", 4'b1000);
    step("mr_rst", 1, 4'b1010, '0, 0, 0);  expect_gnt("mr_rstc", 4'b0000);
    step("mr_g1", 0, 4'b1010, '0, 0, 0);   expect_gnt("mr_g1c", 4'b0010);

`ifdef WB_ARB_TIMEOUT_EN
    // Stalled strobe: watchdog aborts, then the pending master wins.
    step("to_rst", 1, '0, '0, 0, 0);
    step("to_g0", 0, 4'b0001, 4'b0001, 1, 0); expect_gnt("to_g0c", 4'b0001);
    waited = 0;
    while (bus.to_err_o !== 1'b1 && waited < 40) begin
      step("to_wait", 0, 4'b0011, 4'b0001, 1, 0);
      waited++;
    end
    tests++;
    assert (waited === 9) else begin
      fails++; $error("FAIL to_latency observed=%0d expected=%0d", waited, 9);
    end
    expect_gnt("to_abort_gnt", 4'b0000);
    step("to_idle", 0, 4'b0011, 4'b0000, 1, 0); expect_gnt("to_idlec", 4'b0000);
    step("to_g1", 0, 4'b0011, 4'b0000, 1, 0);   expect_gnt("to_g1c", 4'b0010);
`endif

    // Randomized traffic against the model.
    step("rnd_rst", 1, '0, '0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      rq = N'($urandom);
      lk = N'($urandom) & N'($urandom) & N'($urandom);
      step("rnd", ($urandom_range(0, 63) == 0), rq, lk,
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
